// File: rtl/snoop_responder.sv
// MESI line table answering bus snoops with MISS/HIT/HITM after a fixed LATENCY.
// HITM lines are written back as LINE_SIZE/BEAT_W gapless beats; one snoop in flight at a time.
module snoop_responder #(
  parameter int LINE_SIZE = 512,
  parameter int ADDR_W    = 32,
  parameter int ENTRIES   = 8,
  parameter int LATENCY   = 2,
  parameter int BEAT_W    = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [7:0]           req_op,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic                 pl_valid,
  output logic                 pl_ready,
  input  logic [ADDR_W-1:0]    pl_addr,
  input  logic [1:0]           pl_state,
  input  logic [LINE_SIZE-1:0] pl_data,
  output logic                 rsp_valid,
  output logic [1:0]           rsp_snoop,
  output logic                 data_valid,
  output logic [BEAT_W-1:0]    data_beat,
  output logic                 data_last
);

  localparam int OFF_W  = $clog2(LINE_SIZE / 8);
  localparam int TAG_W  = ADDR_W - OFF_W;
  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int BEATS  = LINE_SIZE / BEAT_W;
  localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LCNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);
  localparam logic [LCNT_W-1:0] LAT_END   = LCNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

  localparam logic [1:0] MESI_I = 2'b00;
  localparam logic [1:0] MESI_S = 2'b01;
  localparam logic [1:0] MESI_M = 2'b11;

  localparam logic [7:0] OP_READ = 8'h01;
  localparam logic [7:0] OP_RFO  = 8'h03;
  localparam logic [7:0] OP_INV  = 8'h04;

  localparam logic [1:0] SNP_MISS = 2'b00;
  localparam logic [1:0] SNP_HIT  = 2'b01;
  localparam logic [1:0] SNP_HITM = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2, DATA = 2'd3} state_t;

  state_t state, state_nxt;

  logic [ENTRIES-1:0]   ent_vld;
  logic [1:0]           ent_mesi [ENTRIES];
  logic [TAG_W-1:0]     ent_tag  [ENTRIES];
  logic [LINE_SIZE-1:0] ent_dat  [ENTRIES];
  logic [IDX_W-1:0]     rr_ptr;

  logic [7:0]           lat_op;
  logic                 lat_hit;
  logic [IDX_W-1:0]     lat_idx;
  logic [1:0]           lat_snoop;
  logic [LINE_SIZE-1:0] lat_line;
  logic [LCNT_W-1:0]    lat_cnt;
  logic [BCNT_W-1:0]    beat_cnt;

  logic [TAG_W-1:0] req_tag, pl_tag;
  logic             req_hit, pl_hit;
  logic [IDX_W-1:0] req_idx, pl_idx;
  logic             req_acc, pl_acc, snoop_op;
  logic [1:0]       snoop_lkp;
  logic             unused_off;

  assign req_tag    = req_addr[ADDR_W-1:OFF_W];
  assign pl_tag     = pl_addr[ADDR_W-1:OFF_W];
  assign unused_off = ^{req_addr[OFF_W-1:0], pl_addr[OFF_W-1:0]};
  assign req_acc    = req_valid && req_ready;
  assign pl_acc     = pl_valid && pl_ready;
  assign snoop_op   = (req_op == OP_READ) || (req_op == OP_RFO) || (req_op == OP_INV);

  // Tags are unique in the table (preload overwrites in place), so at most one entry matches.
  always_comb begin
    req_hit = 1'b0;
    req_idx = '0;
    pl_hit  = 1'b0;
    pl_idx  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (ent_vld[i] && ent_tag[i] == req_tag) begin
        req_hit = 1'b1;
        req_idx = IDX_W'(i);
      end
      if (ent_vld[i] && ent_tag[i] == pl_tag) begin
        pl_hit = 1'b1;
        pl_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    snoop_lkp = SNP_MISS;
    if (req_hit && snoop_op && ent_mesi[req_idx] != MESI_I)
      snoop_lkp = (ent_mesi[req_idx] == MESI_M) ? SNP_HITM : SNP_HIT;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_acc) state_nxt = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (lat_cnt == LAT_END) state_nxt = RESP;
      RESP:    state_nxt = (lat_snoop == SNP_HITM) ? DATA : IDLE;
      DATA:    if (beat_cnt == LAST_BEAT) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pl_ready   = (state == IDLE) && !reset;
    req_ready  = (state == IDLE) && !reset && !pl_valid;
    rsp_valid  = (state == RESP);
    rsp_snoop  = (state == RESP) ? lat_snoop : 2'b00;
    data_valid = (state == DATA);
    data_beat  = (state == DATA) ? lat_line[BEAT_W-1:0] : '0;
    data_last  = (state == DATA) && (beat_cnt == LAST_BEAT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent_vld   <= '0;
      rr_ptr    <= '0;
      lat_op    <= '0;
      lat_hit   <= 1'b0;
      lat_idx   <= '0;
      lat_snoop <= SNP_MISS;
      lat_cnt   <= '0;
      beat_cnt  <= '0;
    end else begin
      if (pl_acc) begin
        if (pl_hit) begin
          if (pl_state == MESI_I) begin
            ent_vld[pl_idx] <= 1'b0;
          end else begin
            ent_mesi[pl_idx] <= pl_state;
            ent_dat[pl_idx]  <= pl_data;
          end
        end else if (pl_state != MESI_I) begin
          ent_vld[rr_ptr]  <= 1'b1;
          ent_tag[rr_ptr]  <= pl_tag;
          ent_mesi[rr_ptr] <= pl_state;
          ent_dat[rr_ptr]  <= pl_data;
          rr_ptr           <= rr_ptr + IDX_W'(1);
        end
      end
      // The line is frozen here; nothing can modify the table until the snoop completes.
      if (req_acc) begin
        lat_op    <= req_op;
        lat_hit   <= req_hit;
        lat_idx   <= req_idx;
        lat_snoop <= snoop_lkp;
        lat_line  <= ent_dat[req_idx];
        lat_cnt   <= '0;
        beat_cnt  <= '0;
      end
      if (state == WAIT) lat_cnt <= lat_cnt + LCNT_W'(1);
      if (state == RESP && lat_hit) begin
        if (lat_op == OP_READ)                        ent_mesi[lat_idx] <= MESI_S;
        else if (lat_op == OP_RFO || lat_op == OP_INV) ent_vld[lat_idx]  <= 1'b0;
      end
      if (state == DATA) begin
        beat_cnt <= beat_cnt + BCNT_W'(1);
        lat_line <= lat_line >> BEAT_W;
      end
    end
  end

endmodule

// File: tb/tb_snoop_responder.sv
// Scoreboard bench for snoop_responder: directed scenarios then random traffic against a table model.
module tb_snoop_responder;

  localparam int LS = 512, AW = 32, NE = 4, LATENCY = 2, BW = 64, NBEATS = LS / BW;

  logic          clk, reset;
  logic          req_valid, req_ready, pl_valid, pl_ready;
  logic [7:0]    req_op;
  logic [AW-1:0] req_addr, pl_addr;
  logic [1:0]    pl_state, rsp_snoop;
  logic [LS-1:0] pl_data;
  logic          rsp_valid, data_valid, data_last;
  logic [BW-1:0] data_beat;

  snoop_responder #(.LINE_SIZE(LS), .ADDR_W(AW), .ENTRIES(NE), .LATENCY(LATENCY), .BEAT_W(BW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_addr(pl_addr), .pl_state(pl_state), .pl_data(pl_data),
    .rsp_valid(rsp_valid), .rsp_snoop(rsp_snoop),
    .data_valid(data_valid), .data_beat(data_beat), .data_last(data_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: a small line table with round-robin allocation.
  bit              m_v   [NE];
  logic [1:0]      m_st  [NE];
  logic [AW-7:0]   m_line[NE];
  logic [LS-1:0]   m_dat [NE];
  int              m_ptr;

  function automatic int m_find(input logic [AW-1:0] a);
    for (int i = 0; i < NE; i++)
      if (m_v[i] && m_line[i] == a[AW-1:6]) return i;
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NE; i++) m_v[i] = 1'b0;
    m_ptr = 0;
  endtask

  task automatic model_pl(input logic [AW-1:0] a, input logic [1:0] st, input logic [LS-1:0] d);
    int i;
    i = m_find(a);
    if (i >= 0) begin
      if (st == 2'b00) m_v[i] = 1'b0;
      else begin m_st[i] = st; m_dat[i] = d; end
    end else if (st != 2'b00) begin
      m_v[m_ptr] = 1'b1; m_line[m_ptr] = a[AW-1:6]; m_st[m_ptr] = st; m_dat[m_ptr] = d;
      m_ptr = (m_ptr + 1) % NE;
    end
  endtask

  task automatic model_req(input logic [7:0] op, input logic [AW-1:0] a,
                           output logic [1:0] snp, output logic [LS-1:0] line);
    int i;
    i = m_find(a);
    snp = 2'b00;
    line = '0;
    if (i >= 0 && (op == 8'h01 || op == 8'h03 || op == 8'h04)) begin
      snp = (m_st[i] == 2'b11) ? 2'b10 : 2'b01;
      line = m_dat[i];
      if (op == 8'h01) m_st[i] = 2'b01;
      else m_v[i] = 1'b0;
    end
  endtask

  typedef struct { int cyc; logic [1:0] snp; logic [LS-1:0] line; } exp_t;
  exp_t exp_q[$];

  // Monitor state
  int            flush_req = 0, flush_seen = 0;
  int            beats_left = 0, beat_k = 0;
  bit            chk_idle = 0;
  logic [LS-1:0] cur_line;
  exp_t          mon_e;

  always @(negedge clk) begin
    if (flush_req != flush_seen) begin
      flush_seen = flush_req;
      beats_left = 0;
      beat_k = 0;
      chk_idle = 0;
      exp_q.delete();
    end
    if (!reset) begin
      if (chk_idle) begin
        check("done_pl_ready", 64'(pl_ready), 64'd1);
        check("done_req_ready", 64'(req_ready), 64'(!pl_valid));
        chk_idle = 0;
      end
      if (beats_left > 0) begin
        check("beat_valid", 64'(data_valid), 64'd1);
        check("beat_data", data_beat, cur_line[beat_k*BW +: BW]);
        check("beat_last", 64'(data_last), 64'(beats_left == 1));
        check("busy_pl_ready", 64'(pl_ready), 64'd0);
        beat_k++;
        beats_left--;
        if (beats_left == 0) chk_idle = 1;
      end else begin
        check("data_idle_strobes", 64'({data_valid, data_last}), 64'd0);
        check("data_idle_beat", data_beat, 64'd0);
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL rsp_unexpected: got rsp_snoop %0h at cycle %0d, expected no response", rsp_snoop, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_snoop", 64'(rsp_snoop), 64'(mon_e.snp));
          check("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
          check("busy_pl_ready", 64'(pl_ready), 64'd0);
          if (mon_e.snp == 2'b10) begin
            beats_left = NBEATS; beat_k = 0; cur_line = mon_e.line;
          end else chk_idle = 1;
        end
      end else begin
        check("rsp_idle_snoop", 64'(rsp_snoop), 64'd0);
        if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
          mon_e = exp_q.pop_front();
          n_chk++;
          $display("FAIL rsp_missing: got no rsp_valid by cycle %0d, expected one at cycle %0d", cyc, mon_e.cyc);
        end
      end
    end
  end

  // Driver
  task automatic wait_rdy(input bit want_pl, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = want_pl ? pl_ready : req_ready;
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL %s: got no ready within 200 cycles, expected ready", name);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic accept_req(input logic [7:0] op, input logic [AW-1:0] a, input int exp_snp);
    exp_t e;
    logic [1:0] snp;
    logic [LS-1:0] line;
    @(posedge clk); #1;
    req_valid = 1'b0;
    model_req(op, a, snp, line);
    e.cyc = cyc + LATENCY - 1;
    e.snp = (exp_snp >= 0) ? exp_snp[1:0] : snp;
    e.line = line;
    exp_q.push_back(e);
  endtask

  task automatic do_req(input logic [7:0] op, input logic [AW-1:0] a, input int exp_snp);
    req_op = op; req_addr = a; req_valid = 1'b1;
    wait_rdy(1'b0, "req_ready_timeout");
    accept_req(op, a, exp_snp);
  endtask

  task automatic do_pl(input logic [AW-1:0] a, input logic [1:0] st, input logic [LS-1:0] d);
    pl_addr = a; pl_state = st; pl_data = d; pl_valid = 1'b1;
    wait_rdy(1'b1, "pl_ready_timeout");
    @(posedge clk); #1;
    pl_valid = 1'b0;
    model_pl(a, st, d);
  endtask

  task automatic do_sim(input logic [AW-1:0] pa, input logic [1:0] st, input logic [LS-1:0] d,
                        input logic [7:0] op, input logic [AW-1:0] ra, input int exp_snp);
    pl_addr = pa; pl_state = st; pl_data = d; pl_valid = 1'b1;
    req_op = op; req_addr = ra; req_valid = 1'b1;
    wait_rdy(1'b1, "sim_pl_ready_timeout");
    check("sim_req_ready_low", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    pl_valid = 1'b0;
    model_pl(pa, st, d);
    @(negedge clk);
    check("sim_req_ready_next", 64'(req_ready), 64'd1);
    if (!req_ready) wait_rdy(1'b0, "sim_req_ready_timeout");
    accept_req(op, ra, exp_snp);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && (beats_left == 0) && pl_ready;
    end
    check("drain_done", 64'(done), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush_req++;
    model_clear();
    @(posedge clk);
    @(negedge clk);
    check("rst_strobes", 64'({rsp_valid, rsp_snoop, data_valid, data_last}), 64'd0);
    check("rst_beat", data_beat, 64'd0);
    check("rst_ready_low", 64'({req_ready, pl_ready}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'({req_ready, pl_ready}), 64'b11);
    @(posedge clk); #1;
  endtask

  function automatic logic [LS-1:0] rand_line();
    logic [LS-1:0] d;
    for (int k = 0; k < LS / 32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [LS-1:0] d;
    int nb;
    reset = 1'b1; req_valid = 0; req_op = 0; req_addr = 0;
    pl_valid = 0; pl_addr = 0; pl_state = 0; pl_data = '0;
    do_reset();

    // Miss on empty table
    do_req(8'h01, 32'h1000, 0);
    drain();

    // HITM writeback with beats 1..8, then the line is shared
    for (int k = 0; k < NBEATS; k++) d[k*BW +: BW] = 64'(k + 1);
    do_pl(32'h2040, 2'b11, d);
    do_req(8'h01, 32'h207F, 2);
    do_req(8'h01, 32'h207F, 1);
    drain();

    // RFO invalidates an exclusive line
    do_pl(32'h3000, 2'b10, rand_line());
    do_req(8'h03, 32'h3000, 1);
    do_req(8'h01, 32'h3000, 0);
    drain();

    // Round-robin replacement on a full table
    do_reset();
    for (int k = 0; k < 5; k++) do_pl(32'(k * 64), 2'b01, rand_line());
    do_req(8'h01, 32'h0, 0);
    do_req(8'h01, 32'h40, 1);
    drain();

    // Preload and request in the same cycle
    do_sim(32'h4000, 2'b11, rand_line(), 8'h01, 32'h4000, 2);
    drain();

    // Reset during writeback after the third beat
    do_pl(32'h5000, 2'b11, rand_line());
    do_req(8'h01, 32'h5000, 2);
    nb = 0;
    for (int i = 0; i < 50 && nb < 3; i++) begin
      @(negedge clk);
      if (data_valid) nb++;
    end
    check("beats_before_reset", 64'(nb), 64'd3);
    #1;
    do_reset();
    do_req(8'h01, 32'h5000, 0);
    drain();

    // Random traffic over a small set of lines
    do_reset();
    for (int t = 0; t < 300; t++) begin
      int r;
      logic [AW-1:0] a, a2;
      logic [7:0] op;
      r  = $urandom_range(0, 10);
      a  = 32'h8000 + 32'($urandom_range(0, 5) * 64) + 32'($urandom_range(0, 63));
      a2 = 32'h8000 + 32'($urandom_range(0, 5) * 64) + 32'($urandom_range(0, 63));
      case (r)
        0, 1, 2: op = 8'h01;
        3:       op = 8'h02;
        4:       op = 8'h03;
        5:       op = 8'h04;
        default: op = 8'($urandom_range(0, 255));
      endcase
      if (r <= 6)       do_req(op, a, -1);
      else if (r <= 9)  do_pl(a, 2'($urandom_range(0, 3)), rand_line());
      else              do_sim(a, 2'($urandom_range(0, 3)), rand_line(), op, a2, -1);
      gap($urandom_range(0, 2));
    end
    drain();
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/snoop_responder.md
SNOOP_RESPONDER -- requirements
Module: snoop_responder

Interface
REQ-001 Parameter LINE_SIZE, default 512: cache line width in bits; multiple of BEAT_W.
REQ-002 Parameter ADDR_W, default 32: snoop address width.
REQ-003 Parameter ENTRIES, default 8: tracked lines; power of two, >=2.
REQ-004 Parameter LATENCY, default 2: cycles from request accept to response, >=1.
REQ-005 Parameter BEAT_W, default 64: writeback data beat width.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 req_valid  in  1  snoop request present.
REQ-009 req_ready  out  1  responder can accept a request.
REQ-010 req_op  in  8  bus operation: 0x01 READ, 0x02 WRITE, 0x03 RFO, 0x04 INVALIDATE; other codes are NOP.
REQ-011 req_addr  in  ADDR_W  snoop byte address.
REQ-012 pl_valid  in  1  preload a line into the table.
REQ-013 pl_ready  out  1  preload accepted this cycle.
REQ-014 pl_addr  in  ADDR_W  preload byte address.
REQ-015 pl_state  in  2  MESI state: 00 I, 01 S, 10 E, 11 M.
REQ-016 pl_data  in  LINE_SIZE  preload line data.
REQ-017 rsp_valid  out  1  one-cycle snoop result strobe.
REQ-018 rsp_snoop  out  2  00 MISS, 01 HIT, 10 HITM; 11 never driven.
REQ-019 data_valid  out  1  writeback beat valid.
REQ-020 data_beat  out  BEAT_W  writeback beat.
REQ-021 data_last  out  1  final beat marker.

Function
REQ-022 Tag = address bits [ADDR_W-1:log2(LINE_SIZE/8)]; offset bits ignored on lookup and preload.
REQ-023 FSM states: IDLE, WAIT, RESP, DATA; req_ready = pl_ready = (state==IDLE) && !reset, except req_ready=0 while pl_valid=1.
REQ-024 Preload accept (pl_valid && pl_ready): matching valid entry overwritten in place; otherwise entry at round-robin pointer written, pointer increments modulo ENTRIES; pl_state=I invalidates the matching entry, no allocation.
REQ-025 Request accept at edge T: address/op latched, state -> WAIT; lookup result captured; rsp_valid=1 for exactly the cycle after edge T+LATENCY-1 (LATENCY=1 -> cycle immediately after accept).
REQ-026 Result: no valid matching entry -> MISS; entry S or E -> HIT; entry M -> HITM; WRITE and NOP ops -> MISS regardless of state.
REQ-027 State update applied at end of RESP cycle: READ: M/E -> S, S unchanged; RFO or INVALIDATE: any -> I (entry invalidated); WRITE/NOP: unchanged.
REQ-028 HITM -> DATA state: LINE_SIZE/BEAT_W consecutive beats starting cycle after rsp_valid, beat k = line bits [k*BEAT_W +: BEAT_W], data_last with final beat, no gaps; data captured at RESP, unaffected by later state change.
REQ-029 MISS/HIT -> IDLE after RESP; DATA -> IDLE after last beat; next request accepted no earlier than cycle after return to IDLE.
REQ-030 rsp_valid, data_valid, data_last low outside their defined cycles; rsp_snoop and data_beat zero when their strobe is low.
REQ-031 Table-full preload of new tag evicts the pointer entry without writeback.

Reset
REQ-032 Reset high at a clock edge: state IDLE, all entries invalid, pointer 0, beat/latency counters 0, all outputs 0 next cycle, including mid-WAIT or mid-DATA (remaining beats discarded).
REQ-033 req_ready and pl_ready 1 in the first cycle after reset deasserts.

Verification (LINE_SIZE=512, BEAT_W=64, LATENCY=2, ENTRIES=4)
REQ-034 Miss: READ 0x1000 on empty table -> rsp_valid two cycles after accept, rsp_snoop=00, no data beats, req_ready high next cycle.
REQ-035 HITM writeback: preload 0x2040 M, data beat k = k+1; READ 0x207F -> rsp_snoop=10, 8 beats values 1..8, data_last on 8th; repeat READ -> 01 (now S).
REQ-036 Invalidate: preload 0x3000 E; RFO 0x3000 -> 01; READ 0x3000 -> 00.
REQ-037 Replacement: preload 5 distinct tags 0x0,0x40,0x80,0xC0,0x100 state S -> READ 0x0 returns 00, READ 0x40 returns 01.
REQ-038 Reset during DATA after beat 3 -> data_valid 0 next cycle, READ of that line afterwards -> 00.
REQ-039 Simultaneous pl_valid and req_valid in IDLE -> preload taken, req_ready 0 that cycle, request accepted next cycle and sees preloaded state.
